// File: rtl/iana_stream_arbiter.sv
//------------------------------------------------------------------------------
// Module   : iana_stream_arbiter
// Purpose  : Round-robin merge of two 128-bit record sources onto a 32-bit
//            AXI-Stream S2MM channel, packetised every PKT_RECS records or on flush.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module iana_stream_arbiter #(
    parameter int unsigned PKT_RECS = 16,
    parameter logic [31:0] PAD_WORD = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             pl_clk,
    input  logic             nreset,
    input  logic             a_valid,
    input  logic [127:0]     a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [127:0]     b_data,
    output logic             b_ready,
    input  logic             flush,
    output logic [31:0]      m_tdata,
    output logic [3:0]       m_tkeep,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [CNT_W-1:0] pkt_count,
    output logic             busy
);

    localparam int unsigned     RC_W     = $clog2(PKT_RECS);
    localparam logic [RC_W-1:0] LAST_REC = RC_W'(PKT_RECS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             a_full_q, a_full_d, b_full_q, b_full_d;
    logic [127:0]     a_rec_q, a_rec_d, b_rec_q, b_rec_d;
    logic             sel_q, sel_d;
    logic             rr_q, rr_d;
    logic [1:0]       beat_q, beat_d;
    logic [RC_W-1:0]  rec_cnt_q, rec_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic             a_take, b_take, hs;
    logic [127:0]     sel_rec;

    assign a_ready   = ~a_full_q;
    assign b_ready   = ~b_full_q;
    assign a_take    = a_valid & ~a_full_q;
    assign b_take    = b_valid & ~b_full_q;
    assign m_tkeep   = 4'hF;
    assign m_tvalid  = (state_q != S_IDLE);
    assign pkt_count = pkt_cnt_q;
    assign busy      = (state_q != S_IDLE) | a_full_q | b_full_q;
    assign sel_rec   = sel_q ? b_rec_q : a_rec_q;
    assign hs        = m_tvalid & m_tready;

    // tlast for a data record is decided when beat 3 is first presented, so a
    // flush arriving during a stalled beat 3 cannot change m_tlast mid-stall.
    assign m_tlast = (beat_q == 2'd3) &&
                     ((state_q == S_PAD) || ((state_q == S_SEND) && last_q));

    always_comb begin
        m_tdata = 32'd0;
        case (state_q)
            S_SEND:  m_tdata = sel_rec[{beat_q, 5'd0} +: 32];
            S_PAD:   m_tdata = PAD_WORD;
            default: m_tdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        a_full_d     = a_full_q;
        b_full_d     = b_full_q;
        a_rec_d      = a_rec_q;
        b_rec_d      = b_rec_q;
        sel_d        = sel_q;
        rr_d         = rr_q;
        beat_d       = beat_q;
        rec_cnt_d    = rec_cnt_q;
        last_d       = last_q;
        pkt_cnt_d    = pkt_cnt_q;
        flush_pend_d = flush_pend_q | flush;

        if (a_take) begin
            a_rec_d  = a_data;
            a_full_d = 1'b1;
        end
        if (b_take) begin
            b_rec_d  = b_data;
            b_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                beat_d = 2'd0;
                last_d = 1'b0;
                if (a_full_q || b_full_q) begin
                    state_d = S_SEND;
                    // rr_q names the source that wins when both are waiting
                    sel_d   = (a_full_q && b_full_q) ? rr_q : b_full_q;
                    rr_d    = ~sel_d;
                end else if (flush_pend_q) begin
                    if (rec_cnt_q != '0) state_d = S_PAD;
                    else                 flush_pend_d = 1'b0;
                end
            end
            S_SEND, S_PAD: begin
                if (hs) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd2)
                        last_d = (rec_cnt_q == LAST_REC) | flush_pend_q | flush;
                    if (beat_q == 2'd3) begin
                        state_d = S_IDLE;
                        if (state_q == S_SEND) begin
                            if (sel_q) b_full_d = 1'b0;
                            else       a_full_d = 1'b0;
                            rec_cnt_d = rec_cnt_q + RC_W'(1);
                        end
                        if (m_tlast) begin
                            rec_cnt_d    = '0;
                            flush_pend_d = 1'b0;
                            pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            a_full_q     <= 1'b0;
            b_full_q     <= 1'b0;
            a_rec_q      <= '0;
            b_rec_q      <= '0;
            sel_q        <= 1'b0;
            rr_q         <= 1'b0;
            beat_q       <= 2'd0;
            rec_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            last_q       <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            a_full_q     <= a_full_d;
            b_full_q     <= b_full_d;
            a_rec_q      <= a_rec_d;
            b_rec_q      <= b_rec_d;
            sel_q        <= sel_d;
            rr_q         <= rr_d;
            beat_q       <= beat_d;
            rec_cnt_q    <= rec_cnt_d;
            flush_pend_q <= flush_pend_d;
            last_q       <= last_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iana_stream_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_iana_stream_arbiter
// Purpose  : Self-checking bench for iana_stream_arbiter.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iana_stream_arbiter;

    localparam int PKT = 16;

    logic         pl_clk = 1'b0;
    logic         nreset;
    logic         a_valid, b_valid, flush, m_tready;
    logic [127:0] a_data, b_data;
    logic         a_ready, b_ready, m_tlast, m_tvalid, busy;
    logic [31:0]  m_tdata;
    logic [3:0]   m_tkeep;
    logic [15:0]  pkt_count;

    int passes = 0;
    int checks = 0;
    bit rnd_en = 1'b0;

    typedef struct {
        logic [127:0] rec;
        logic [3:0]   lastm;
    } rx_t;

    rx_t          rxq[$];
    logic [127:0] qa[$];
    logic [127:0] qb[$];
    rx_t          cur;
    int           mon_beat = 0;
    bit           stall_prev = 1'b0;
    logic [31:0]  pdata;
    logic         plast;

    iana_stream_arbiter dut (
        .pl_clk   (pl_clk),
        .nreset   (nreset),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .flush    (flush),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .pkt_count(pkt_count),
        .busy     (busy)
    );

    always #5 pl_clk = ~pl_clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passes++;
    endtask

    function automatic logic [127:0] mkrec(input logic [31:0] tag, input int i);
        logic [31:0] b;
        b = tag | (32'(i) << 4);
        return {b | 32'd3, b | 32'd2, b | 32'd1, b};
    endfunction

    // Observer: assembles output beats into records, logs accepted inputs,
    // and enforces AXIS hold-stable behaviour across stalls.
    always @(negedge pl_clk) begin
        if (!nreset) begin
            mon_beat   = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_tvalid", m_tvalid, 1'b1);
                check("stall_tdata", m_tdata, pdata);
                check("stall_tlast", m_tlast, plast);
            end
            stall_prev = m_tvalid && !m_tready;
            pdata      = m_tdata;
            plast      = m_tlast;
            if (a_valid && a_ready) qa.push_back(a_data);
            if (b_valid && b_ready) qb.push_back(b_data);
            if (m_tvalid && m_tready) begin
                cur.rec[mon_beat*32 +: 32] = m_tdata;
                cur.lastm[mon_beat]        = m_tlast;
                if (mon_beat == 3) begin
                    rxq.push_back(cur);
                    mon_beat = 0;
                end else begin
                    mon_beat++;
                end
            end
        end
    end

    always @(posedge pl_clk) begin
        if (rnd_en) begin
            #1;
            m_tready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic clear_logs();
        rxq.delete();
        qa.delete();
        qb.delete();
    endtask

    task automatic do_reset();
        nreset  = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        flush   = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge pl_clk);
        #1;
        nreset = 1'b1;
        @(posedge pl_clk);
        #1;
        clear_logs();
    endtask

    task automatic feed(input bit src, input int n, input logic [31:0] tag, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [127:0] d;
            int guard;
            if (rnd) begin
                repeat ($urandom_range(0, 3)) @(posedge pl_clk);
                #1;
                d = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                d = mkrec(tag, i);
            end
            if (src) begin b_data = d; b_valid = 1'b1; end
            else     begin a_data = d; a_valid = 1'b1; end
            guard = 0;
            @(negedge pl_clk);
            while (!(src ? b_ready : a_ready) && guard < 2000) begin
                @(negedge pl_clk);
                guard++;
            end
            if (guard >= 2000) begin
                checks++;
                $display("FAIL feed_timeout: waited %0d cycles, limit 2000", guard);
            end
            @(posedge pl_clk);
            #1;
            if (src) b_valid = 1'b0;
            else     a_valid = 1'b0;
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c;
        c = 0;
        while (rxq.size() < n && c < budget) begin
            @(posedge pl_clk);
            #1;
            c++;
        end
        check("rx_count", rxq.size(), n);
    endtask

    task automatic wait_tvalid();
        int c;
        c = 0;
        @(negedge pl_clk);
        while (!m_tvalid && c < 200) begin
            @(negedge pl_clk);
            c++;
        end
        check("tvalid_seen", m_tvalid, 1'b1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge pl_clk);
        #1;
        flush = 1'b0;
    endtask

    typedef struct {
        logic        av;
        logic        tv;
        logic [31:0] td;
        logic        tl;
        logic        ar;
        logic        bs;
    } vec_t;

    vec_t         tbl[7];
    logic [127:0] r;
    logic [31:0]  w0;
    int           cnt;
    bit           hit;

    initial begin
        // single-record trace, one row per cycle from acceptance
        tbl[0] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0};

        nreset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0; m_tready = 1'b1;
        a_data = '0; b_data = '0;
        #1 nreset = 1'b0;
        repeat (2) @(posedge pl_clk);
        #1;
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_b_ready", b_ready, 1'b1);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tkeep", m_tkeep, 4'hF);
        check("rst_pkt", pkt_count, 16'd0);
        check("rst_busy", busy, 1'b0);
        nreset = 1'b1;
        @(posedge pl_clk);
        #1;

        // single record, word i = i
        a_data = {32'd3, 32'd2, 32'd1, 32'd0};
        for (int k = 0; k < 7; k++) begin
            a_valid = tbl[k].av;
            @(negedge pl_clk);
            check($sformatf("t1_tvalid[%0d]", k), m_tvalid, tbl[k].tv);
            if (tbl[k].tv) check($sformatf("t1_tdata[%0d]", k), m_tdata, tbl[k].td);
            check($sformatf("t1_tlast[%0d]", k), m_tlast, tbl[k].tl);
            check($sformatf("t1_a_ready[%0d]", k), a_ready, tbl[k].ar);
            check($sformatf("t1_busy[%0d]", k), busy, tbl[k].bs);
            @(posedge pl_clk);
            #1;
        end

        // both sources continuously valid: strict alternation A,B,A,B
        do_reset();
        fork
            feed(1'b0, 8, 32'hA000_0000, 1'b0);
            feed(1'b1, 8, 32'hB000_0000, 1'b0);
        join
        wait_rx(16, 400);
        for (int k = 0; k < rxq.size(); k++) begin
            check($sformatf("alt_rec[%0d]", k), rxq[k].rec,
                  (k % 2 == 0) ? mkrec(32'hA000_0000, k / 2) : mkrec(32'hB000_0000, k / 2));
        end

        // full packet of 16 A records
        do_reset();
        feed(1'b0, 16, 32'hC000_0000, 1'b0);
        wait_rx(16, 400);
        for (int k = 0; k < rxq.size(); k++) begin
            check($sformatf("pkt_rec[%0d]", k), rxq[k].rec, mkrec(32'hC000_0000, k));
            check($sformatf("pkt_last[%0d]", k), rxq[k].lastm, (k == PKT - 1) ? 4'b1000 : 4'b0000);
        end
        check("pkt_count_16", pkt_count, 16'd1);
        pulse_flush();
        repeat (20) @(posedge pl_clk);
        #1;
        check("pkt_flush_dropped_rx", rxq.size(), 16);
        check("pkt_flush_dropped_cnt", pkt_count, 16'd1);
        check("pkt_idle_busy", busy, 1'b0);

        // short packet closed by a flush while idle -> filler record
        do_reset();
        feed(1'b0, 3, 32'hD000_0000, 1'b0);
        wait_rx(3, 200);
        pulse_flush();
        wait_rx(4, 100);
        if (rxq.size() >= 4) begin
            check("pad_data", rxq[3].rec, {4{32'hFFFF_FFFF}});
            check("pad_last", rxq[3].lastm, 4'b1000);
            check("pad_prev_last", rxq[2].lastm, 4'b0000);
        end
        check("pad_pkt", pkt_count, 16'd1);
        pulse_flush();
        repeat (20) @(posedge pl_clk);
        #1;
        check("pad_second_rx", rxq.size(), 4);
        check("pad_second_pkt", pkt_count, 16'd1);

        // flush during beat 1 of record 5 terminates on that record
        do_reset();
        feed(1'b0, 4, 32'hE000_0000, 1'b0);
        wait_rx(4, 200);
        feed(1'b0, 1, 32'hE100_0000, 1'b0);
        wait_tvalid();
        @(posedge pl_clk);
        #1;
        pulse_flush();
        wait_rx(5, 100);
        repeat (20) @(posedge pl_clk);
        #1;
        check("fl5_rx", rxq.size(), 5);
        if (rxq.size() >= 5) begin
            check("fl5_rec", rxq[4].rec, mkrec(32'hE100_0000, 0));
            check("fl5_last", rxq[4].lastm, 4'b1000);
            check("fl5_prev_last", rxq[3].lastm, 4'b0000);
        end
        check("fl5_pkt", pkt_count, 16'd1);

        // random traffic with random back-pressure against queue model
        do_reset();
        rnd_en = 1'b1;
        fork
            feed(1'b0, 20, 32'h0, 1'b1);
            feed(1'b1, 20, 32'h0, 1'b1);
        join
        wait_rx(40, 4000);
        rnd_en = 1'b0;
        @(posedge pl_clk);
        #2;
        m_tready = 1'b1;
        cnt = 0;
        for (int k = 0; k < rxq.size(); k++) begin
            hit = 1'b0;
            if (qa.size() > 0 && rxq[k].rec === qa[0]) begin
                void'(qa.pop_front());
                hit = 1'b1;
            end else if (qb.size() > 0 && rxq[k].rec === qb[0]) begin
                void'(qb.pop_front());
                hit = 1'b1;
            end
            check($sformatf("rnd_rec[%0d]", k), hit, 1'b1);
            check($sformatf("rnd_last[%0d]", k), rxq[k].lastm, (cnt == PKT - 1) ? 4'b1000 : 4'b0000);
            cnt = (cnt + 1) % PKT;
        end
        check("rnd_pkt", pkt_count, 16'(40 / PKT));

        // asynchronous reset mid-record abandons the packet
        clear_logs();
        feed(1'b0, 1, 32'h5000_0000, 1'b0);
        wait_tvalid();
        @(posedge pl_clk);
        #3;
        nreset = 1'b0;
        #1;
        check("mid_rst_tvalid", m_tvalid, 1'b0);
        check("mid_rst_tdata", m_tdata, 32'd0);
        check("mid_rst_tlast", m_tlast, 1'b0);
        check("mid_rst_a_ready", a_ready, 1'b1);
        check("mid_rst_b_ready", b_ready, 1'b1);
        check("mid_rst_pkt", pkt_count, 16'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tkeep", m_tkeep, 4'hF);
        @(posedge pl_clk);
        #1;
        nreset = 1'b1;
        @(posedge pl_clk);
        #1;
        clear_logs();
        feed(1'b0, 1, 32'h6000_0000, 1'b0);
        r  = mkrec(32'h6000_0000, 0);
        w0 = r[31:0];
        wait_tvalid();
        check("post_rst_beat0", m_tdata, w0);
        wait_rx(1, 50);
        if (rxq.size() >= 1) begin
            check("post_rst_rec", rxq[0].rec, r);
            check("post_rst_last", rxq[0].lastm, 4'b0000);
        end
        check("post_rst_pkt", pkt_count, 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
